// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, frame-length helpers and bit reversal for the FFT sequencer
package fft_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    localparam int MAX_LOG2N = 10;
    localparam int DEF_LOG2N = 3;
    localparam int DEF_N     = 1 << DEF_LOG2N;

    function automatic int fft_n(input int log2n);
        return 1 << log2n;
    endfunction

    // Reverses the low log2n bits of idx; higher bits come back as zero
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx, input int log2n);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < log2n; i++) r[log2n-1-i] = idx[i];
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: load, butterfly and drain handshakes between the sequencer and its datapath
interface fft_frame_sequencer_if #(
    parameter int LOG2N = 3,
    parameter int AW    = LOG2N
);
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             bf_valid;
    logic             bf_ready;
    logic [AW-1:0]    bf_addr_a;
    logic [AW-1:0]    bf_addr_b;
    logic [LOG2N-2:0] bf_tw;
    logic             bf_done;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    rd_addr;
    logic             out_last;

    modport master (
        input  in_valid, bf_ready, bf_done, out_ready,
        output in_ready, wr_en, wr_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw,
               out_valid, rd_addr, out_last
    );

    modport slave (
        output in_valid, bf_ready, bf_done, out_ready,
        input  in_ready, wr_en, wr_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw,
               out_valid, rd_addr, out_last
    );
endinterface

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: combinational DIT butterfly operand and twiddle addresses for one (stage, butterfly) pair
module fft_bf_addr_gen #(
    parameter int LOG2N = 3,
    parameter int AW    = LOG2N,
    parameter int SW    = $clog2(LOG2N + 1)
) (
    input  logic [SW-1:0]    i_stage,
    input  logic [LOG2N-1:0] i_bf_cnt,
    output logic [AW-1:0]    o_addr_a,
    output logic [AW-1:0]    o_addr_b,
    output logic [LOG2N-2:0] o_tw
);
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_a;

    // Group index doubles into the lower operand base, position within the group selects the twiddle
    always_comb begin
        w_half   = LOG2N'(1) << i_stage;
        w_pos    = i_bf_cnt & (w_half - 1'b1);
        w_a      = ((i_bf_cnt >> i_stage) << (i_stage + 1'b1)) + w_pos;
        o_addr_a = AW'(w_a);
        o_addr_b = AW'(w_a + w_half);
        o_tw     = (LOG2N-1)'(w_pos << (LOG2N - 1 - int'(i_stage)));
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: bit-reversed load, stage-barriered butterfly issue and natural-order drain of one FFT frame
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int AW    = LOG2N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    output logic                  busy,
    output logic                  err,
    fft_frame_sequencer_if.master bus
);
    localparam int N    = fft_n(LOG2N);
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOG2N + 1);

    state_t           r_state, w_next;
    logic [LOG2N-1:0] r_ld_cnt, r_bf_cnt, r_done_cnt, r_rd_cnt;
    logic [SW-1:0]    r_stage;
    logic             r_err;
    logic             w_hs_in, w_hs_bf, w_hs_out;
    logic             w_full, w_barrier, w_last_stage, w_done_ok;
    logic [AW-1:0]    w_gen_a, w_gen_b;
    logic [LOG2N-2:0] w_gen_tw;

    fft_bf_addr_gen #(.LOG2N(LOG2N), .AW(AW), .SW(SW)) u_addr_gen (
        .i_stage  (r_stage),
        .i_bf_cnt (r_bf_cnt),
        .o_addr_a (w_gen_a),
        .o_addr_b (w_gen_b),
        .o_tw     (w_gen_tw)
    );

    assign w_full       = r_bf_cnt == LOG2N'(HALF);
    assign w_barrier    = (r_state == COMPUTE) && w_full && (r_done_cnt == LOG2N'(HALF));
    assign w_last_stage = r_stage == SW'(LOG2N - 1);

    assign busy          = r_state != IDLE;
    assign err           = r_err;
    assign bus.in_ready  = ena && (r_state == LOAD);
    assign bus.wr_en     = bus.in_valid & bus.in_ready;
    assign bus.wr_addr   = AW'(bitrev(MAX_LOG2N'(r_ld_cnt), LOG2N));
    assign bus.bf_valid  = ena && (r_state == COMPUTE) && !w_full;
    assign bus.bf_addr_a = (r_state == COMPUTE) ? w_gen_a : '0;
    assign bus.bf_addr_b = (r_state == COMPUTE) ? w_gen_b : '0;
    assign bus.bf_tw     = (r_state == COMPUTE) ? w_gen_tw : '0;
    assign bus.out_valid = ena && (r_state == DRAIN);
    assign bus.rd_addr   = AW'(r_rd_cnt);
    assign bus.out_last  = bus.out_valid && (r_rd_cnt == LOG2N'(N - 1));

    assign w_hs_in  = bus.in_valid & bus.in_ready;
    assign w_hs_bf  = bus.bf_valid & bus.bf_ready;
    assign w_hs_out = bus.out_valid & bus.out_ready;

    // A completion is legal only while it does not overtake the requests issued so far, including this cycle's
    assign w_done_ok = bus.bf_done && (r_state == COMPUTE) &&
                       ({1'b0, r_done_cnt} < {1'b0, r_bf_cnt} + {{LOG2N{1'b0}}, w_hs_bf});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; everything holds while ena is low
    always_comb begin
        w_next = r_state;
        if (ena)
            case (r_state)
                IDLE:    w_next = start ? LOAD : IDLE;
                LOAD:    w_next = (w_hs_in && r_ld_cnt == LOG2N'(N - 1)) ? COMPUTE : LOAD;
                COMPUTE: w_next = (w_barrier && w_last_stage) ? DRAIN : COMPUTE;
                DRAIN:   w_next = (w_hs_out && bus.out_last) ? IDLE : DRAIN;
                default: w_next = IDLE;
            endcase
    end

    // Load, stage, issue and drain counters advance on their own handshakes; load and drain wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt <= '0;
            r_stage  <= '0;
            r_bf_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    r_ld_cnt <= '0;
                    r_stage  <= '0;
                    r_bf_cnt <= '0;
                    r_rd_cnt <= '0;
                end
                LOAD:    r_ld_cnt <= r_ld_cnt + LOG2N'(w_hs_in);
                COMPUTE: begin
                    r_stage  <= r_stage + SW'(w_barrier);
                    r_bf_cnt <= w_barrier ? '0 : r_bf_cnt + LOG2N'(w_hs_bf);
                end
                DRAIN:   r_rd_cnt <= r_rd_cnt + LOG2N'(w_hs_out);
                default: ;
            endcase
        end
    end

    // Completions are tracked even with ena low since the datapath keeps running; stray ones latch err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (ena && (r_state == IDLE || w_barrier)) r_done_cnt <= '0;
            else if (w_done_ok)                       r_done_cnt <= r_done_cnt + 1'b1;
            if (bus.bf_done && !w_done_ok) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized frames checked against a pair-list schedule model of the FFT sequencer
module tb_fft_frame_sequencer;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int H     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic start = 1'b0;
    logic busy, err;

    fft_frame_sequencer_if #(.LOG2N(LOG2N)) bus_if ();

    fft_frame_sequencer #(.LOG2N(LOG2N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .busy  (busy),
        .err   (err),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    int   ea[LOG2N][H];
    int   eb[LOG2N][H];
    int   et[LOG2N][H];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) if ((k >> i) & 1) r |= 1 << (LOG2N - 1 - i);
        return r;
    endfunction

    // Stage s pairs every address whose bit s is clear with its partner half away, in ascending order
    task automatic build_schedule();
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            int idx = 0;
            for (int a = 0; a < N; a++)
                if (((a / half) % 2) == 0) begin
                    ea[s][idx] = a;
                    eb[s][idx] = a + half;
                    et[s][idx] = (a % half) * (H / half);
                    idx++;
                end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, bus_if.in_ready, 0);
        chk({tag, "_wr_en"}, bus_if.wr_en, 0);
        chk({tag, "_bf_valid"}, bus_if.bf_valid, 0);
        chk({tag, "_out_valid"}, bus_if.out_valid, 0);
        chk({tag, "_out_last"}, bus_if.out_last, 0);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_wr_addr"}, bus_if.wr_addr, 0);
        chk({tag, "_rd_addr"}, bus_if.rd_addr, 0);
        chk({tag, "_bf_addr_a"}, bus_if.bf_addr_a, 0);
        chk({tag, "_bf_addr_b"}, bus_if.bf_addr_b, 0);
        chk({tag, "_bf_tw"}, bus_if.bf_tw, 0);
    endtask

    task automatic do_load(input bit ena_drop, input bit inject, input bit rnd);
        int  k = 0;
        int  n = 0;
        bit  dropped = 0;
        bit  injected = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", bus_if.in_ready, 1);
        while (k < N && n < 200) begin
            n++;
            if (ena_drop && k == 3 && !dropped) begin
                dropped = 1;
                ena = 1'b0;
                bus_if.in_valid = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    #1;
                    chk("ena_low_wr_en", bus_if.wr_en, 0);
                    chk("ena_low_in_ready", bus_if.in_ready, 0);
                    chk("ena_low_wr_addr", bus_if.wr_addr, rev(3));
                    @(posedge clk);
                    @(negedge clk);
                end
                ena = 1'b1;
            end
            bus_if.in_valid = rnd ? ($urandom % 4 != 0) : 1'b1;
            bus_if.bf_done = inject && k == 5 && !injected;
            if (bus_if.bf_done) injected = 1;
            #1;
            chk("load_in_ready", bus_if.in_ready, 1);
            chk("load_wr_en", bus_if.wr_en, bus_if.in_valid);
            chk("load_err", err, exp_err);
            if (bus_if.in_valid) chk("load_wr_addr", bus_if.wr_addr, rev(k));
            @(posedge clk);
            if (bus_if.in_valid) k++;
            if (bus_if.bf_done) exp_err = 1'b1;
            @(negedge clk);
            bus_if.bf_done = 1'b0;
        end
        bus_if.in_valid = 1'b0;
        #1;
        chk("load_count", k, N);
        chk("load_in_ready_end", bus_if.in_ready, 0);
        chk("load_err_end", err, exp_err);
        @(negedge clk);
    endtask

    // Datapath stand-in: each accepted request owes one completion, returned no earlier than the next cycle
    task automatic do_compute(input bit stall, input bit withhold, input int abort);
        int s = 0, b = 0, d = 0, owed = 0, hold = 0, n = 0;
        bit held = 0;
        bit exp_v;
        while (s < LOG2N && n < 1000 && !(abort > 0 && n >= abort)) begin
            n++;
            bus_if.bf_ready = stall ? ($urandom % 3 != 0) : 1'b1;
            if (withhold && s == 0 && b == H && !held) begin
                held = 1;
                hold = 20;
            end
            bus_if.bf_done = (owed > 0 && hold == 0);
            #1;
            exp_v = b < H;
            chk("bf_valid", bus_if.bf_valid, exp_v);
            chk("compute_busy", busy, 1);
            chk("compute_out_valid", bus_if.out_valid, 0);
            if (exp_v) begin
                chk("bf_addr_a", bus_if.bf_addr_a, ea[s][b]);
                chk("bf_addr_b", bus_if.bf_addr_b, eb[s][b]);
                chk("bf_tw", bus_if.bf_tw, et[s][b]);
            end
            @(posedge clk);
            if (b == H && d == H) begin
                s++;
                b = 0;
                d = 0;
            end else begin
                if (bus_if.bf_done) begin
                    d++;
                    owed--;
                end
                if (exp_v && bus_if.bf_ready) begin
                    b++;
                    owed++;
                end
            end
            if (hold > 0) hold--;
            @(negedge clk);
            bus_if.bf_done = 1'b0;
        end
        bus_if.bf_ready = 1'b0;
        bus_if.bf_done = 1'b0;
        if (abort == 0) chk("compute_stages", s, LOG2N);
    endtask

    task automatic do_drain(input bit toggle);
        int idx = 0, n = 0;
        bit t = 1;
        while (idx < N && n < 200) begin
            n++;
            bus_if.out_ready = toggle ? t : 1'($urandom % 2);
            t = !t;
            start = !toggle && ($urandom % 3 == 0);
            #1;
            chk("drain_out_valid", bus_if.out_valid, 1);
            chk("drain_rd_addr", bus_if.rd_addr, idx);
            chk("drain_out_last", bus_if.out_last, idx == N - 1);
            chk("drain_busy", busy, 1);
            chk("drain_bf_valid", bus_if.bf_valid, 0);
            @(posedge clk);
            if (bus_if.out_ready) idx++;
            @(negedge clk);
        end
        bus_if.out_ready = 1'b0;
        start = 1'b0;
        #1;
        chk("drain_count", idx, N);
        chk("drain_busy_end", busy, 0);
        chk("drain_out_valid_end", bus_if.out_valid, 0);
        chk("drain_in_ready_end", bus_if.in_ready, 0);
        chk("drain_err_end", err, exp_err);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.bf_ready  = 1'b0;
        bus_if.bf_done   = 1'b0;
        bus_if.out_ready = 1'b0;
        build_schedule();
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        ena = 1'b1;
        @(negedge clk);

        do_load(0, 0, 0);
        do_compute(0, 0, 0);
        do_drain(1);

        do_load(1, 1, 1);
        do_compute(1, 1, 0);
        do_drain(0);

        do_load(0, 0, 1);
        do_compute(0, 0, 7);
        #2;
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(0, 0, 1);
        do_compute(1, 0, 0);
        do_drain(0);
        #1;
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
